// File: rtl/if_array_rr_arbiter_if.sv
// simple_if: one requester lane.
//   data  - request strobe (1 = requesting)
//   value - 8-bit payload presented with the request
// The arbiter consumes this lane through the sink modport; the
// producer drives it through the source modport.
interface simple_if;
  logic       data;
  logic [7:0] value;

  modport sink   (input  data, input  value);
  modport source (output data, output value);
endinterface

// File: rtl/if_array_rr_arbiter.sv
// if_array_rr_arbiter: round-robin arbiter sharing one 8-bit valid/ready
// output slot among N simple_if requesters.
//
// Ports:
//   clk         - clock, all state updates on posedge
//   rst_n       - asynchronous active-low reset
//   req_ifs     - requester array (data = request, value = payload)
//   out_valid   - output slot holds a captured payload
//   out_ready   - consumer accepts the slot this cycle when out_valid is high
//   out_data    - captured payload
//   out_id      - index of the requester that owns out_data
//   grant       - one-hot, one-cycle pulse to the requester just captured
//   grant_count - captures since reset, wraps modulo 2^16
//
// Every output comes straight from a flop; req_ifs and out_ready only
// steer next-state logic.
module if_array_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  simple_if.sink               req_ifs [N-1:0],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [$clog2(N)-1:0] out_id,
  output logic [N-1:0]         grant,
  output logic [15:0]          grant_count
);

  localparam int IW = $clog2(N);

  typedef logic [IW-1:0] idx_t;
  // One extra bit so ptr + offset can exceed N before wrapping.
  typedef logic [IW:0]   ext_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic [N-1:0] req_s;
  logic [7:0]   val_s [N];
  logic [N-1:0] eligible_s;

  idx_t         ptr_r;
  idx_t         win_s;
  idx_t         ptr_next_s;
  ext_t         idx_s;
  logic         found_s;
  logic         slot_free_s;
  logic         capture_s;

  logic [7:0]   out_data_r;
  idx_t         out_id_r;
  logic [N-1:0] grant_r;
  logic [15:0]  count_r;

  // Flatten the interface array; interface elements need constant indices.
  for (genvar g = 0; g < N; g++) begin : g_flatten
    assign req_s[g] = req_ifs[g].data;
    assign val_s[g] = req_ifs[g].value;
  end

  // A requester is masked during its own grant cycle so it can drop or
  // refresh its request before being considered again.
  assign eligible_s = req_s & ~grant_r;

  // Circular priority scan starting at ptr_r; first eligible index wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = ext_t'(ptr_r) + ext_t'(k);
      idx_s = (idx_s >= ext_t'(N)) ? (idx_s - ext_t'(N)) : idx_s;
      if (!found_s && eligible_s[idx_s[IW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[IW-1:0];
      end else begin
        found_s = found_s;
        win_s   = win_s;
      end
    end
  end

  // Pointer moves to the index just after the winner, wrapping at N-1.
  always_comb begin
    if (win_s == idx_t'(N - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = win_s + idx_t'(1);
    end
  end

  assign slot_free_s = (state_r == EMPTY) || out_ready;
  assign capture_s   = slot_free_s && found_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a free slot refills if anyone is eligible, else empties.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (capture_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (!out_ready) begin
          state_next_s = FULL;
        end else if (capture_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // Output decode: out_valid is the registered state itself.
  always_comb begin
    out_valid = 1'b0;
    case (state_r)
      EMPTY:   out_valid = 1'b0;
      FULL:    out_valid = 1'b1;
      default: out_valid = 1'b0;
    endcase
  end

  // Datapath: load payload/id/pointer/count on capture; grant is a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r <= 8'd0;
      out_id_r   <= '0;
      grant_r    <= '0;
      count_r    <= 16'd0;
      ptr_r      <= '0;
    end else if (capture_s) begin
      out_data_r <= val_s[win_s];
      out_id_r   <= win_s;
      grant_r    <= {{(N-1){1'b0}}, 1'b1} << win_s;
      count_r    <= count_r + 16'd1;
      ptr_r      <= ptr_next_s;
    end else begin
      grant_r    <= '0;
    end
  end

  assign out_data    = out_data_r;
  assign out_id      = out_id_r;
  assign grant       = grant_r;
  assign grant_count = count_r;

endmodule

// File: tb/tb_if_array_rr_arbiter.sv
// Self-checking bench for if_array_rr_arbiter (N = 4). A behavioural model
// (circular search over the request array, plain integers) predicts the
// outputs after every clock edge; directed steps cover the listed scenarios
// and a randomized phase mixes requests, payloads and backpressure.
module tb_if_array_rr_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         out_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_id;
  logic [N-1:0] grant;
  logic [15:0]  grant_count;

  logic [N-1:0] req_tb;
  logic [7:0]   val_tb [N];

  simple_if ifs [N-1:0] ();

  for (genvar g = 0; g < N; g++) begin : g_drive
    assign ifs[g].data  = req_tb[g];
    assign ifs[g].value = val_tb[g];
  end

  if_array_rr_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_ifs     (ifs),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .grant       (grant),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  logic        m_valid;
  logic [7:0]  m_data;
  int          m_id;
  int          m_gid;     // index granted last edge, -1 if none
  int          m_ptr;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'd0;
    m_id    = 0;
    m_gid   = -1;
    m_ptr   = 0;
    m_cnt   = 16'd0;
  endtask

  // Apply the arbitration rules to the inputs present before the edge.
  task automatic model_step();
    int w;
    int i;
    w = -1;
    if (!m_valid || out_ready) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (w < 0 && req_tb[i] && i != m_gid) w = i;
      end
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = val_tb[w];
        m_id    = w;
        m_gid   = w;
        m_ptr   = (w + 1) % N;
        m_cnt   = m_cnt + 16'd1;
      end else begin
        m_valid = 1'b0;
        m_gid   = -1;
      end
    end else begin
      m_gid = -1;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_grant;
    exp_grant = (m_gid < 0) ? '0 : (N'(1) << m_gid);
    chk("out_valid",   32'(out_valid),   32'(m_valid));
    chk("out_data",    32'(out_data),    32'(m_data));
    chk("out_id",      32'(out_id),      32'(m_id));
    chk("grant",       32'(grant),       32'(exp_grant));
    chk("grant_count", 32'(grant_count), 32'(m_cnt));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Async reset between edges, checked before the next edge, released
  // before the following posedge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid",   32'(out_valid),   32'd0);
    chk("rst_out_data",    32'(out_data),    32'd0);
    chk("rst_grant",       32'(grant),       32'd0);
    chk("rst_grant_count", 32'(grant_count), 32'd0);
    #3;
    rst_n = 1'b1;
  endtask

  int cnt_id [N];

  initial begin
    // ---- reset with all requests high
    rst_n     = 1'b0;
    out_ready = 1'b1;
    req_tb    = 4'b1111;
    for (int i = 0; i < N; i++) val_tb[i] = 8'(10 + i);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_rst_valid", 32'(out_valid),   32'd0);
    chk("hold_rst_grant", 32'(grant),       32'd0);
    chk("hold_rst_count", 32'(grant_count), 32'd0);
    rst_n = 1'b1;

    // ---- rotation 0,1,2,3,0,...
    for (int s = 0; s < 8; s++) begin
      tick();
      chk("rot_id",   32'(out_id),   32'(s % N));
      chk("rot_data", 32'(out_data), 32'(10 + (s % N)));
      chk("rot_grant", 32'(grant),   32'(4'b0001 << (s % N)));
    end

    // ---- backpressure on a lone requester 2
    req_tb = 4'b0000;
    repeat (2) tick();
    req_tb    = 4'b0100;
    val_tb[2] = 8'h5A;
    out_ready = 1'b0;
    repeat (6) tick();
    chk("bp_data", 32'(out_data), 32'h5A);
    chk("bp_id",   32'(out_id),   32'd2);
    out_ready = 1'b1;
    repeat (6) tick();

    // ---- fairness between 1 and 3
    req_tb = 4'b1010;
    for (int i = 0; i < N; i++) cnt_id[i] = 0;
    for (int s = 0; s < 300 && (cnt_id[1] + cnt_id[3]) < 100; s++) begin
      tick();
      if (grant != '0) cnt_id[out_id]++;
    end
    chk("fair_id1", 32'(cnt_id[1]), 32'd50);
    chk("fair_id3", 32'(cnt_id[3]), 32'd50);

    // ---- pointer wrap and back-to-back reload
    req_tb = 4'b0000;
    repeat (2) tick();
    req_tb = 4'b0100;
    tick();                       // 2 captured, ptr -> 3
    req_tb = 4'b1001;
    tick();
    chk("wrap_id_a", 32'(out_id), 32'd3);
    tick();
    chk("wrap_id_b", 32'(out_id), 32'd0);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    tick();
    chk("wrap_id_c", 32'(out_id), 32'd3);

    // ---- async reset during a stall
    req_tb    = 4'b0010;
    out_ready = 1'b0;
    repeat (3) tick();
    async_reset();
    req_tb    = 4'b1111;
    out_ready = 1'b1;
    tick();
    chk("post_rst_id", 32'(out_id), 32'd0);
    repeat (3) tick();

    // ---- randomized traffic
    for (int s = 0; s < 400; s++) begin
      req_tb    = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) val_tb[i] = 8'($urandom);
      tick();
    end

    // ---- grant_count wrap after 65536 captures
    out_ready = 1'b1;
    req_tb    = 4'b0011;
    async_reset();
    for (int s = 0; s < 65535; s++) tick();
    chk("cnt_ffff", 32'(grant_count), 32'h0000FFFF);
    tick();
    chk("cnt_wrap", 32'(grant_count), 32'h00000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_array_rr_arbiter.md
# if_array_rr_arbiter

Round-robin arbiter that shares one downstream 8-bit channel among an array of `simple_if` requesters. Each array element raises `data` to request and presents its payload on `value`. The arbiter loops over the array, picks one requester per free slot, and registers its payload into a valid/ready output stage. It pulses a per-requester grant and keeps a running grant count. It sits between a `simple_if` array, driven by producer loops, and a single consumer.

## Interface
- `N`, default 4: number of requesters (2..16).
- `clk` input 1: clock; all state updates on posedge.
- `rst_n` input 1: reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `req_ifs` input `simple_if.sink [N-1:0]`: requester array. `req_ifs[i].data` = request, `req_ifs[i].value` = 8-bit payload.
- `out_valid` output 1: output slot holds a captured payload.
- `out_ready` input 1: consumer accepts the slot this cycle when `out_valid` is high.
- `out_data` output 8: captured payload.
- `out_id` output `$clog2(N)`: index of the requester that owns `out_data`.
- `grant` output N: one-hot, registered; one-cycle pulse to the winner.
- `grant_count` output 16: total captures since reset, wraps modulo 2^16.

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `out_id`=0, `grant`=0, `grant_count`=0, priority pointer `ptr`=0.
- Two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- The slot is free in a cycle if the state is EMPTY, or if the state is FULL and `out_ready`=1.
- Eligible requesters: `req_ifs[i].data`=1 and `grant[i]`=0. A requester is masked during its own grant cycle so it has time to drop or update its request.
- Winner: the first eligible index found scanning `ptr, ptr+1, ..., ptr+N-1` modulo N.
- Capture, at a clock edge where the slot is free and at least one requester is eligible:
  - `out_data` <= `req_ifs[w].value`
  - `out_id` <= w
  - `out_valid` <= 1
  - `grant` <= one-hot(w)
  - `ptr` <= (w+1) mod N
  - `grant_count` <= `grant_count`+1
  - State goes to or stays FULL.
- Slot free but no eligible requester: `out_valid` <= 0, `grant` <= 0, state EMPTY, `ptr` unchanged.
- State FULL and `out_ready`=0: all outputs hold. `grant` <= 0, so `grant` is never high for more than one cycle per capture.
- `out_data`, `out_id` and `out_valid` never change while `out_valid`=1 and `out_ready`=0.
- `out_ready` is ignored while `out_valid`=0.
- Deasserting a request before it is granted is legal: the requester simply loses eligibility, with no state retained.

## Timing
- Latency: request sampled at edge T produces `out_valid`, `out_data`, `out_id` and `grant` at T+1. No combinational path from `req_ifs` or `out_ready` to any output.
- Throughput: one capture per cycle while `out_ready`=1 and two or more requesters are active.
- A single persistent requester gets captured every other cycle because of the grant-cycle mask.
- Accept and capture in the same cycle (FULL, `out_ready`=1, eligible request present): the slot reloads with no bubble.
- Accept with no eligible request: `out_valid` falls at the next edge.
- `ptr` wraps from N-1 to 0.
- `grant_count` wraps 16'hFFFF -> 16'h0000 with no flag.
- Reset asserted mid-transfer: all outputs take their reset values immediately (asynchronous) and the pending slot is discarded. The first capture after release occurs at the first posedge with `rst_n`=1.
- `req_ifs` is sampled only at posedge. A glitch between edges has no effect.

## Test plan
- Reset: hold `rst_n`=0 with all four requests high -> `out_valid`=0, `grant`=0, `grant_count`=0. Release, values 10/11/12/13, `out_ready`=1 -> `out_id` sequence 0,1,2,3,0,...; `out_data` 10,11,12,13; `grant` pulses 0001,0010,0100,1000.
- Backpressure: requester 2 only, value 8'h5A, `out_ready`=0 for 5 cycles -> `out_valid`=1, `out_data`=8'h5A, `out_id`=2 stable, `grant[2]` high exactly 1 cycle, `grant_count`=1. Then `out_ready`=1 -> next capture 2 cycles after the previous grant.
- Fairness: requesters 1 and 3 continuous, `out_ready`=1 -> strict alternation 1,3,1,3. After 100 captures, each id owns exactly 50.
- Pointer wrap: N=4, `ptr`=3, requests {0,3} -> 3 wins, then 0, then 3.
- Back-to-back accept: FULL with `out_ready`=1 and request 0 pending -> `out_valid` stays 1 across the edge, `out_id` changes to 0, no bubble.
- Async reset mid-stall: FULL with `out_ready`=0, pull `rst_n` low between edges -> `out_valid`, `out_data`, `grant_count` go to 0 before the next edge. After release, the first capture starts from `ptr`=0.
- Counter wrap: force 65536 captures -> `grant_count` returns to 16'h0000.
